// File: rtl/frame_downsampler_pkg.sv
// Constants and FSM encoding shared by the frame loader, downsampler and TX reader.
`timescale 1ns/1ps
package frame_downsampler_pkg;

   localparam int IMG_W  = 512;
   localparam int PIX_W  = 8;
   localparam int SRC_AW = 2 * $clog2(IMG_W);
   localparam int DST_AW = 2 * $clog2(IMG_W / 2);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READ  = 3'd1,
      ST_DRAIN = 3'd2,
      ST_WRITE = 3'd3,
      ST_DONE  = 3'd4
   } fd_state_t;

endpackage

// File: rtl/frame_downsampler_avg4_acc.sv
// Four-tap pixel accumulator with clear/add and a round-half-up divide-by-4 result.
`timescale 1ns/1ps
module avg4_acc #(
   parameter int PIX_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             add_en,
   input  logic [PIX_W-1:0] din,
   output logic [PIX_W-1:0] avg
);

   // Two guard bits: 4*max + 2 still fits.
   logic [PIX_W+1:0] acc;
   logic [PIX_W+1:0] acc_rnd;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
      end else if (clr) begin
         acc <= '0;
      end else if (add_en) begin
         acc <= acc + {2'b00, din};
      end
   end

   assign acc_rnd = acc + (PIX_W + 2)'(2);
   assign avg     = acc_rnd[PIX_W+1:2];

endmodule

// File: rtl/frame_downsampler.sv
// Reads a stored IMG_W x IMG_W frame, averages each 2x2 block and writes the half-size frame.
`timescale 1ns/1ps
module frame_downsampler #(
   parameter int IMG_W  = frame_downsampler_pkg::IMG_W,
   parameter int PIX_W  = frame_downsampler_pkg::PIX_W,
   parameter int SRC_AW = 2 * $clog2(IMG_W),
   parameter int DST_AW = 2 * $clog2(IMG_W / 2)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic [SRC_AW-1:0] src_addr,
   input  logic [PIX_W-1:0]  src_data,
   output logic [DST_AW-1:0] dst_addr,
   output logic [PIX_W-1:0]  dst_data,
   output logic              dst_wen,
   output logic              busy,
   output logic              done
);

   import frame_downsampler_pkg::*;

   localparam int CW = $clog2(IMG_W) - 1;

   fd_state_t      state;
   fd_state_t      state_nx;
   logic [CW-1:0]  ox;
   logic [CW-1:0]  oy;
   logic [1:0]     k;
   logic           start_q;
   logic           start_armed;
   logic           start_edge;
   logic           last_pix;
   logic           acc_clr;
   logic           acc_add;
   logic [PIX_W-1:0] avg;

   // start_armed stays low until start has been seen low, so a level already
   // high when reset releases never counts as an edge.
   assign start_edge = start & ~start_q & start_armed;
   assign last_pix   = (&ox) & (&oy);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         start_q     <= 1'b0;
         start_armed <= 1'b0;
      end else begin
         start_q     <= start;
         start_armed <= start_armed | ~start;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:  if (start_edge) state_nx = ST_READ;
         ST_READ:  if (k == 2'd3) state_nx = ST_DRAIN;
         ST_DRAIN: state_nx = ST_WRITE;
         ST_WRITE: state_nx = last_pix ? ST_DONE : ST_READ;
         ST_DONE:  if (!start) state_nx = ST_IDLE;
         default:  state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ox <= '0;
         oy <= '0;
         k  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start_edge) begin
                  ox <= '0;
                  oy <= '0;
                  k  <= '0;
               end
            end
            ST_READ: k <= k + 2'd1;
            ST_WRITE: begin
               k <= '0;
               if (!last_pix) begin
                  ox <= ox + 1'b1;
                  if (&ox) oy <= oy + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Tap address is the block base plus {k[1]*IMG_W + k[0]}, which for a
   // power-of-two width is just bit insertion.
   always_comb begin
      src_addr = '0;
      dst_addr = '0;
      dst_data = '0;
      dst_wen  = 1'b0;
      if (state == ST_READ) src_addr = {oy, k[1], ox, k[0]};
      if (state == ST_WRITE) begin
         dst_addr = {oy, ox};
         dst_data = avg;
         dst_wen  = 1'b1;
      end
   end

   assign busy    = (state == ST_READ) || (state == ST_DRAIN) || (state == ST_WRITE);
   assign done    = (state == ST_DONE);
   assign acc_clr = ((state == ST_IDLE) && start_edge) || (state == ST_WRITE);
   assign acc_add = ((state == ST_READ) && (k != 2'd0)) || (state == ST_DRAIN);

   avg4_acc #(
      .PIX_W (PIX_W)
   ) u_avg4_acc (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (acc_clr),
      .add_en (acc_add),
      .din    (src_data),
      .avg    (avg)
   );

endmodule

// File: tb/tb_frame_downsampler.sv
// Bench for frame_downsampler on an 8x8 frame against a 2x2 rounding-average model.
`timescale 1ns/1ps
module tb_frame_downsampler;

   localparam int IMG_W     = 8;
   localparam int PIX_W     = 8;
   localparam int SRC_AW    = 6;
   localparam int DST_AW    = 4;
   localparam int OW        = IMG_W / 2;
   localparam int NPIX      = OW * OW;
   localparam int FRAME_CYC = 1 + 6 * NPIX;

   logic              clk;
   logic              rst_n;
   logic              start;
   logic [SRC_AW-1:0] src_addr;
   logic [PIX_W-1:0]  src_data;
   logic [DST_AW-1:0] dst_addr;
   logic [PIX_W-1:0]  dst_data;
   logic              dst_wen;
   logic              busy;
   logic              done;

   frame_downsampler #(
      .IMG_W  (IMG_W),
      .PIX_W  (PIX_W),
      .SRC_AW (SRC_AW),
      .DST_AW (DST_AW)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .src_addr (src_addr),
      .src_data (src_data),
      .dst_addr (dst_addr),
      .dst_data (dst_data),
      .dst_wen  (dst_wen),
      .busy     (busy),
      .done     (done)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // synchronous source RAM model
   logic [PIX_W-1:0] src_mem [IMG_W*IMG_W];
   always @(posedge clk) src_data <= src_mem[src_addr];

   // destination write monitor
   logic [PIX_W-1:0]  got_data_q [$];
   logic [DST_AW-1:0] got_addr_q [$];
   always @(negedge clk) begin
      if (dst_wen === 1'b1) begin
         got_data_q.push_back(dst_data);
         got_addr_q.push_back(dst_addr);
      end
   end

   // scoreboard
   logic [PIX_W-1:0]  exp_q [$];
   logic [SRC_AW-1:0] addr_trace [6];
   int n_checks;
   int n_errors;
   int frame_cycles;
   logic busy_dropped;

   task automatic fill_random();
      for (int i = 0; i < IMG_W * IMG_W; i++) src_mem[i] = PIX_W'($urandom_range(0, 255));
   endtask

   task automatic build_expected();
      int b;
      int s;
      exp_q.delete();
      for (int oy = 0; oy < OW; oy++) begin
         for (int ox = 0; ox < OW; ox++) begin
            b = 2 * oy * IMG_W + 2 * ox;
            s = int'(src_mem[b]) + int'(src_mem[b+1]) + int'(src_mem[b+IMG_W]) + int'(src_mem[b+IMG_W+1]);
            exp_q.push_back(PIX_W'((s + 2) / 4));
         end
      end
   endtask

   task automatic clear_got();
      got_data_q.delete();
      got_addr_q.delete();
   endtask

   task automatic run_frame();
      clear_got();
      @(negedge clk) start = 1'b0;
      repeat (2) @(negedge clk);
      start = 1'b1;
      frame_cycles = 0;
      busy_dropped = 1'b0;
      while (frame_cycles < FRAME_CYC + 50) begin
         @(posedge clk);
         #1;
         frame_cycles++;
         if (frame_cycles <= 6) addr_trace[frame_cycles-1] = src_addr;
         if (done === 1'b1) break;
         if (busy !== 1'b1) busy_dropped = 1'b1;
      end
   endtask

   task automatic check_frame(input string name);
      n_checks++;
      if (frame_cycles !== FRAME_CYC) begin
         n_errors++;
         $display("FAIL %s frame_cycles got=%0d exp=%0d", name, frame_cycles, FRAME_CYC);
      end
      n_checks++;
      if (busy_dropped !== 1'b0) begin
         n_errors++;
         $display("FAIL %s busy_low_mid_frame got=%0b exp=0", name, busy_dropped);
      end
      n_checks++;
      if (got_data_q.size() != NPIX) begin
         n_errors++;
         $display("FAIL %s write_count got=%0d exp=%0d", name, got_data_q.size(), NPIX);
      end
      for (int i = 0; i < NPIX && i < got_data_q.size(); i++) begin
         n_checks++;
         if (got_addr_q[i] !== DST_AW'(i) || got_data_q[i] !== exp_q[i]) begin
            n_errors++;
            $display("FAIL %s write[%0d] got addr=%0d data=%0d exp addr=%0d data=%0d",
                     name, i, got_addr_q[i], got_data_q[i], i, exp_q[i]);
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({src_addr, dst_addr, dst_data, dst_wen, busy, done} !== '0) begin
         n_errors++;
         $display("FAIL reset_outputs got src=%0d dst=%0d data=%0d wen=%0b busy=%0b done=%0b exp all 0",
                  src_addr, dst_addr, dst_data, dst_wen, busy, done);
      end
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if ({dst_wen, busy, done} !== 3'b000) begin
         n_errors++;
         $display("FAIL idle_after_reset got wen=%0b busy=%0b done=%0b exp 0 0 0", dst_wen, busy, done);
      end
   endtask

   task automatic test_constant();
      for (int i = 0; i < IMG_W * IMG_W; i++) src_mem[i] = 8'h80;
      build_expected();
      run_frame();
      check_frame("constant");
      n_checks++;
      if (got_data_q.size() != NPIX || got_data_q[0] !== 8'h80 || got_data_q[NPIX-1] !== 8'h80) begin
         n_errors++;
         $display("FAIL constant_value got size=%0d exp 0x80 everywhere", got_data_q.size());
      end
   endtask

   task automatic test_ramp();
      for (int i = 0; i < IMG_W * IMG_W; i++) src_mem[i] = PIX_W'(i);
      build_expected();
      run_frame();
      check_frame("ramp");
      n_checks++;
      if (got_data_q.size() != NPIX || got_data_q[0] !== 8'd5 || got_data_q[NPIX-1] !== 8'd59) begin
         n_errors++;
         $display("FAIL ramp_corners got size=%0d exp dst[0]=5 dst[15]=59", got_data_q.size());
      end
      n_checks++;
      if (addr_trace[0] !== 6'd0 || addr_trace[1] !== 6'd1 || addr_trace[2] !== 6'd8 ||
          addr_trace[3] !== 6'd9 || addr_trace[4] !== 6'd0) begin
         n_errors++;
         $display("FAIL ramp_src_addr got %0d %0d %0d %0d %0d exp 0 1 8 9 0",
                  addr_trace[0], addr_trace[1], addr_trace[2], addr_trace[3], addr_trace[4]);
      end
   endtask

   task automatic test_rounding();
      fill_random();
      src_mem[0] = 8'd1;   src_mem[1] = 8'd1;   src_mem[8] = 8'd1;   src_mem[9] = 8'd2;
      src_mem[2] = 8'd1;   src_mem[3] = 8'd1;   src_mem[10] = 8'd2;  src_mem[11] = 8'd2;
      src_mem[4] = 8'd255; src_mem[5] = 8'd255; src_mem[12] = 8'd255; src_mem[13] = 8'd255;
      build_expected();
      run_frame();
      check_frame("rounding");
      n_checks++;
      if (got_data_q.size() < 3 || got_data_q[0] !== 8'd1 || got_data_q[1] !== 8'd2 ||
          got_data_q[2] !== 8'd255) begin
         n_errors++;
         $display("FAIL rounding_blocks got size=%0d exp 1 2 255", got_data_q.size());
      end
   endtask

   task automatic test_restart();
      fill_random();
      build_expected();
      run_frame();
      check_frame("restart_first");
      clear_got();
      repeat (20) @(posedge clk);
      #1;
      n_checks++;
      if (got_data_q.size() != 0 || done !== 1'b1 || busy !== 1'b0) begin
         n_errors++;
         $display("FAIL start_held got writes=%0d done=%0b busy=%0b exp 0 1 0",
                  got_data_q.size(), done, busy);
      end
      @(negedge clk) start = 1'b0;
      @(posedge clk);
      #1;
      n_checks++;
      if (done !== 1'b0) begin
         n_errors++;
         $display("FAIL done_release got=%0b exp=0", done);
      end
      run_frame();
      check_frame("restart_second");
   endtask

   task automatic test_reset_mid();
      int w;
      fill_random();
      build_expected();
      clear_got();
      @(negedge clk) start = 1'b0;
      repeat (2) @(negedge clk);
      start = 1'b1;
      w = 0;
      while (got_data_q.size() < 5 && w < 200) begin
         @(posedge clk);
         w++;
      end
      n_checks++;
      if (got_data_q.size() < 5) begin
         n_errors++;
         $display("FAIL reset_mid_wait got writes=%0d exp 5", got_data_q.size());
      end
      @(posedge clk);
      @(posedge clk);
      #1;
      n_checks++;
      if (busy !== 1'b1 || src_addr === 6'd0) begin
         n_errors++;
         $display("FAIL reset_mid_pre got busy=%0b src=%0d exp busy=1 src!=0", busy, src_addr);
      end
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({src_addr, dst_addr, dst_data, dst_wen, busy, done} !== '0) begin
         n_errors++;
         $display("FAIL reset_mid_async got src=%0d wen=%0b busy=%0b done=%0b exp all 0",
                  src_addr, dst_wen, busy, done);
      end
      repeat (3) @(negedge clk);
      clear_got();
      rst_n = 1'b1;
      busy_dropped = 1'b0;
      repeat (30) begin
         @(posedge clk);
         #1;
         if (busy !== 1'b0) busy_dropped = 1'b1;
      end
      n_checks++;
      if (got_data_q.size() != 0 || busy_dropped !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_release_start_high got writes=%0d busy_seen=%0b exp 0 0",
                  got_data_q.size(), busy_dropped);
      end
      run_frame();
      check_frame("after_reset");
   endtask

   task automatic test_random();
      for (int f = 0; f < 3; f++) begin
         fill_random();
         build_expected();
         run_frame();
         check_frame("random");
      end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      test_reset();
      test_constant();
      test_ramp();
      test_rounding();
      test_restart();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
